pipeline_stall_controller: RTL

//   Central stall/flush sequencer for the 5-stage pipeline. Merges the load-use stall

---
 rtl/pipeline_stall_controller.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer: merges load-use, branch flush and memory wait
// into pipeline enables, with timeout error and perf counters.
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_haz_i,
    input  logic             branch_taken_i,
    input  logic             mem_access_i,
    input  logic             mem_ready_i,
    input  logic             perf_clr_i,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             id_ex_bubble,
    output logic             pipe_hold,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              err_nxt;
    logic              freeze;
    logic              decode;
    logic              brk;
    logic              lu_stall;

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        err_nxt   = mem_timeout_err;
        freeze    = 1'b0;
        decode    = 1'b0;
        unique case (state)
            S_RUN: begin
                if (mem_access_i && !mem_ready_i) begin
                    freeze = 1'b1;
                    if (MEM_TIMEOUT == 1) begin
                        state_nxt = S_ERR;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                        wait_nxt  = WAIT_W'(1);
                    end
                end else begin
                    decode = 1'b1;
                end
            end
            S_WAIT: begin
                if (!mem_ready_i) begin
                    freeze = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt = S_ERR;
                        err_nxt   = 1'b1;
                    end else begin
                        wait_nxt = wait_cnt + WAIT_W'(1);
                    end
                end else begin
                    decode    = 1'b1;
                    wait_nxt  = '0;
                    state_nxt = S_RUN;
                end
            end
            S_ERR: begin
                freeze = 1'b1;
            end
            default: begin
                state_nxt = S_RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    // Branch outranks load-use: the load-use victim is flushed anyway.
    assign brk      = decode && branch_taken_i;
    assign lu_stall = decode && !branch_taken_i && load_use_haz_i;

    assign pc_write_en    = !(freeze || lu_stall);
    assign if_id_write_en = !(freeze || lu_stall);
    assign id_ex_bubble   = lu_stall;
    assign pipe_hold      = freeze;
    assign if_id_flush    = brk;
    assign id_ex_flush    = brk;
    assign ex_mem_flush   = brk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_RUN;
            wait_cnt        <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            state           <= state_nxt;
            wait_cnt        <= wait_nxt;
            mem_timeout_err <= err_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (perf_clr_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write_en && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (brk && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
